// File: rtl/dcache_dm.sv
// Blocking direct-mapped write-through, no-write-allocate data cache ahead of MEM.
// Define DCACHE_UNCACHED_IO_EN to make addr[31:28]==4'hF uncached (single-word I/O reads).
module dcache_dm #(
    parameter int INDEX_W      = 6,
    parameter int LINE_WORDS_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  is_dmem,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        DCache_ready,
    output logic [31:0] data_DCache,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int TAG_LSB = INDEX_W + LINE_WORDS_W + 2;
    localparam int TAG_W   = 32 - TAG_LSB;
    localparam int LINES   = 1 << INDEX_W;
    localparam int DEPTH   = 1 << (INDEX_W + LINE_WORDS_W);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] REFILL   = 3'd1;
    localparam logic [2:0] RESP     = 3'd2;
    localparam logic [2:0] WRITE    = 3'd3;
`ifdef DCACHE_UNCACHED_IO_EN
    localparam logic [2:0] UNCACHED = 3'd4;
`endif

    localparam logic [LINE_WORDS_W-1:0] CNT_ONE = 1;

    logic [2:0]              r_state;
    logic [LINE_WORDS_W-1:0] r_cnt;
    logic [31:0]             r_resp;
    logic [LINES-1:0]        r_valid;
    logic [TAG_W-1:0]        r_tag  [LINES];
    logic [31:0]             r_data [DEPTH];

    logic [LINE_WORDS_W-1:0] w_word;
    logic [INDEX_W-1:0]      w_idx;
    logic [TAG_W-1:0]        w_tag;
    logic                    w_load;
    logic                    w_store;
    logic                    w_uc;
    logic                    w_hit;
    logic                    w_last;
    logic [31:0]             w_rd_word;
    logic [31:0]             w_merged;

    assign w_word    = addr[LINE_WORDS_W+1:2];
    assign w_idx     = addr[TAG_LSB-1:LINE_WORDS_W+2];
    assign w_tag     = addr[31:TAG_LSB];
    assign w_load    = (is_dmem == 2'b01);
    assign w_store   = (is_dmem == 2'b10);
`ifdef DCACHE_UNCACHED_IO_EN
    assign w_uc      = (addr[31:28] == 4'hF);
`else
    assign w_uc      = 1'b0;
`endif
    assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag) && !w_uc;
    assign w_last    = &r_cnt;
    assign w_rd_word = r_data[{w_idx, w_word}];

    always_comb begin
        w_merged = w_rd_word;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) w_merged[8*b +: 8] = wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_resp  <= '0;
            r_valid <= '0;
        end else begin
            case (r_state)
                IDLE: begin
`ifdef DCACHE_UNCACHED_IO_EN
                    if (w_load && w_uc) begin
                        r_state <= UNCACHED;
                    end else
`endif
                    if (w_load && !w_hit) begin
                        // line is invalid while being overwritten
                        r_state        <= REFILL;
                        r_cnt          <= '0;
                        r_valid[w_idx] <= 1'b0;
                    end else if (w_store) begin
                        r_state <= WRITE;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        if (r_cnt == w_word) r_resp <= mem_rdata;
                        r_cnt <= r_cnt + CNT_ONE;
                        if (w_last) begin
                            r_valid[w_idx] <= 1'b1;
                            r_state        <= RESP;
                        end
                    end
                end
                RESP: r_state <= IDLE;
                WRITE: begin
                    if (mem_ack) r_state <= IDLE;
                end
`ifdef DCACHE_UNCACHED_IO_EN
                UNCACHED: begin
                    if (mem_ack) r_state <= IDLE;
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == REFILL && mem_ack) begin
                r_data[{w_idx, r_cnt}] <= mem_rdata;
                if (w_last) r_tag[w_idx] <= w_tag;
            end
            if (r_state == WRITE && mem_ack && w_hit) begin
                r_data[{w_idx, w_word}] <= w_merged;
            end
        end
    end

    always_comb begin
        DCache_ready = 1'b0;
        data_DCache  = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = {addr[31:2], 2'b00};
        mem_wdata    = wdata;
        mem_wstrb    = wstrb;
        case (r_state)
            IDLE: begin
                if (w_load && w_hit) begin
                    DCache_ready = 1'b1;
                    data_DCache  = w_rd_word;
                end else if (!w_load && !w_store) begin
                    DCache_ready = 1'b1;
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {w_tag, w_idx, r_cnt, 2'b00};
            end
            RESP: begin
                DCache_ready = 1'b1;
                data_DCache  = r_resp;
            end
            WRITE: begin
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                DCache_ready = mem_ack;
            end
`ifdef DCACHE_UNCACHED_IO_EN
            UNCACHED: begin
                mem_req      = 1'b1;
                DCache_ready = mem_ack;
                if (mem_ack) data_DCache = mem_rdata;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dcache_dm.sv
// Directed bench for dcache_dm with a single-word memory responder.
// Uncached I/O checks run only when DCACHE_UNCACHED_IO_EN is defined.
module tb_dcache_dm;

    logic        clk;
    logic        rst;
    logic [1:0]  is_dmem;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        DCache_ready;
    logic [31:0] data_DCache;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    logic        stray;
    logic [31:0] rd_log [$];
    logic [31:0] last_wa;
    logic [31:0] last_wd;
    logic [3:0]  last_ws;
    logic [31:0] mem_ov [logic [31:0]];

    dcache_dm dut (
        .clk          (clk),
        .rst          (rst),
        .is_dmem      (is_dmem),
        .addr         (addr),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .DCache_ready (DCache_ready),
        .data_DCache  (data_DCache),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_ov.exists(a)) return mem_ov[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic mem_write(input logic [31:0] a, d, input logic [3:0] s);
        logic [31:0] w;
        w = mem_read(a);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        end
        mem_ov[a] = w;
    endtask

    // ack every other cycle while a request is up
    always begin
        @(posedge clk);
        #2;
        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req) begin
            mem_ack = 1'b1;
            if (mem_we) begin
                mem_write(mem_addr, mem_wdata, mem_wstrb);
                last_wa = mem_addr;
                last_wd = mem_wdata;
                last_ws = mem_wstrb;
                wr_cnt++;
            end else begin
                mem_rdata = mem_read(mem_addr);
                rd_log.push_back(mem_addr);
                rd_cnt++;
            end
        end else if (stray) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hDEAD_BEEF;
            stray     = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_op(
        input  logic [1:0]  op,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        input  logic [3:0]  ws,
        output logic [31:0] d,
        output int          cyc,
        output logic        req_r,
        output logic        ack_r
    );
        is_dmem = op;
        addr    = a;
        wdata   = wd;
        wstrb   = ws;
        cyc     = 0;
        #1;
        while (!DCache_ready && cyc < 50) begin
            @(posedge clk);
            #5;
            cyc++;
        end
        check("op_done", {31'b0, DCache_ready}, 32'd1);
        d     = data_DCache;
        req_r = mem_req;
        ack_r = mem_ack;
        @(posedge clk);
        #4;
        is_dmem = 2'b00;
    endtask

    initial begin
        logic [31:0] d;
        int          cyc;
        logic        rq;
        logic        ak;
        int          r0;
        int          w0;

        rst     = 1'b1;
        is_dmem = 2'b00;
        addr    = '0;
        wdata   = '0;
        wstrb   = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        stray   = 1'b0;
        mem_ov[32'h104] = 32'h1122_3344;

        repeat (2) @(posedge clk);
        #4;
        check("rst_ready", {31'b0, DCache_ready}, 32'd1);
        check("rst_req", {31'b0, mem_req}, 32'd0);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        check("rst_data", data_DCache, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #4;

        // load miss: 4-word refill from word 0
        r0 = rd_cnt;
        do_op(2'b01, 32'h100, 0, 0, d, cyc, rq, ak);
        check("t1_reads", 32'(rd_cnt - r0), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check("t1_addr", rd_log[r0+k], 32'h100 + 32'(4*k));
        end
        check("t1_data", d, 32'hA5A5_0100);
        r0 = rd_cnt;
        do_op(2'b01, 32'h100, 0, 0, d, cyc, rq, ak);
        check("t1_hit_cyc", 32'(cyc), 32'd0);
        check("t1_hit_req", {31'b0, rq}, 32'd0);
        check("t1_hit_data", d, 32'hA5A5_0100);
        check("t1_hit_reads", 32'(rd_cnt - r0), 32'd0);

        do_op(2'b01, 32'h108, 0, 0, d, cyc, rq, ak);
        check("t2_cyc", 32'(cyc), 32'd0);
        check("t2_data", d, 32'hA5A5_0108);

        // store hit: write-through plus byte merge into the line
        r0 = rd_cnt;
        w0 = wr_cnt;
        do_op(2'b10, 32'h104, 32'hAABB_CCDD, 4'b0011, d, cyc, rq, ak);
        check("t3_writes", 32'(wr_cnt - w0), 32'd1);
        check("t3_waddr", last_wa, 32'h104);
        check("t3_wstrb", {28'b0, last_ws}, 32'h3);
        check("t3_wdata", last_wd, 32'hAABB_CCDD);
        check("t3_ack_rdy", {31'b0, ak}, 32'd1);
        do_op(2'b01, 32'h104, 0, 0, d, cyc, rq, ak);
        check("t3_cyc", 32'(cyc), 32'd0);
        check("t3_data", d, 32'h1122_CCDD);
        check("t3_reads", 32'(rd_cnt - r0), 32'd0);

        // store miss: no allocate
        r0 = rd_cnt;
        w0 = wr_cnt;
        do_op(2'b10, 32'h2000, 32'hCAFE_F00D, 4'b1111, d, cyc, rq, ak);
        check("t4_writes", 32'(wr_cnt - w0), 32'd1);
        check("t4_noread", 32'(rd_cnt - r0), 32'd0);
        do_op(2'b01, 32'h2000, 0, 0, d, cyc, rq, ak);
        check("t4_reads", 32'(rd_cnt - r0), 32'd4);
        check("t4_addr0", rd_log[r0], 32'h2000);
        check("t4_data", d, 32'hCAFE_F00D);

        // 0x500 and 0x100 share index 0x10
        r0 = rd_cnt;
        do_op(2'b01, 32'h500, 0, 0, d, cyc, rq, ak);
        check("t5_reads_a", 32'(rd_cnt - r0), 32'd4);
        check("t5_data_a", d, 32'hA5A5_0500);
        r0 = rd_cnt;
        do_op(2'b01, 32'h100, 0, 0, d, cyc, rq, ak);
        check("t5_reads_b", 32'(rd_cnt - r0), 32'd4);
        check("t5_data_b", d, 32'hA5A5_0100);

        r0 = rd_cnt;
        w0 = wr_cnt;
        do_op(2'b11, 32'h100, 0, 0, d, cyc, rq, ak);
        check("t5_nop_cyc", 32'(cyc), 32'd0);
        check("t5_nop_req", {31'b0, rq}, 32'd0);
        check("t5_nop_mem", 32'(rd_cnt - r0 + wr_cnt - w0), 32'd0);

        // reset during refill, on the cycle of the second ack
        r0 = rd_cnt;
        is_dmem = 2'b01;
        addr    = 32'h300;
        begin
            int k;
            k = 0;
            while ((rd_cnt - r0) < 2 && k < 60) begin
                @(posedge clk);
                #4;
                k++;
            end
        end
        check("t6_two_acks", 32'(rd_cnt - r0), 32'd2);
        rst     = 1'b1;
        is_dmem = 2'b00;
        @(posedge clk);
        #4;
        check("t6_req_drop", {31'b0, mem_req}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #4;
        stray = 1'b1;
        @(posedge clk);
        #4;
        check("t6_stray_req", {31'b0, mem_req}, 32'd0);
        check("t6_stray_rdy", {31'b0, DCache_ready}, 32'd1);
        @(posedge clk);
        #4;
        r0 = rd_cnt;
        do_op(2'b01, 32'h300, 0, 0, d, cyc, rq, ak);
        check("t6_reads", 32'(rd_cnt - r0), 32'd4);
        check("t6_addr0", rd_log[r0], 32'h300);
        check("t6_data", d, 32'hA5A5_0300);

`ifdef DCACHE_UNCACHED_IO_EN
        for (int n = 0; n < 2; n++) begin
            r0 = rd_cnt;
            do_op(2'b01, 32'hF000_0000, 0, 0, d, cyc, rq, ak);
            check("t7_reads", 32'(rd_cnt - r0), 32'd1);
            check("t7_ack_rdy", {31'b0, ak}, 32'd1);
            check("t7_data", d, 32'h55A5_0000);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
